// File: rtl/frfb_sram_resp.sv
// Frame-buffer bus responder: runs single-word requests on an async SRAM
// with programmable wait states and returns a per-direction done pulse.
module frfb_sram_resp #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16,
    parameter int INIT_CYCLES = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int ACK_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sys_addr,
    input  logic              sys_adsn,
    input  logic              sys_r_wn,
    input  logic [DATA_W-1:0] sys_wdata,
    output logic [DATA_W-1:0] sys_rdata,
    output logic              sys_init_done,
    output logic              done_w,
    output logic              done_r,
    output logic              sys_err,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    // state    | meaning
    // INIT     | power-up settle count, requests ignored
    // IDLE     | waiting for sys_adsn
    // W_SETUP  | chip enabled, data driven, we_n still high
    // W_PULSE  | we_n low for WAIT_CYCLES
    // W_HOLD   | we_n high, data and ce_n held
    // R_SETUP  | chip and output enabled
    // R_WAIT   | read access time, data captured on exit
    // ACK      | done pulse for ACK_CYCLES
    typedef enum logic [2:0] {
        INIT, IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT, ACK
    } state_t;

    localparam int WW = $clog2(WAIT_CYCLES) + 1;
    localparam int KW = $clog2(ACK_CYCLES) + 1;
    localparam int IW = $clog2(INIT_CYCLES + 1);

    localparam logic [WW-1:0] WAIT_LD = WW'(WAIT_CYCLES - 1);
    localparam logic [KW-1:0] ACK_LD  = KW'(ACK_CYCLES - 1);
    localparam logic [IW-1:0] INIT_TC = IW'(INIT_CYCLES);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [KW-1:0] ack_cnt;
    logic [IW-1:0] init_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT;
            wait_cnt      <= '0;
            ack_cnt       <= '0;
            init_cnt      <= '0;
            sys_init_done <= 1'b0;
            done_w        <= 1'b0;
            done_r        <= 1'b0;
            sys_err       <= 1'b0;
            sram_dq_oe    <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_addr     <= '0;
            sram_dq_o     <= '0;
            sys_rdata     <= '0;
        end else begin
            // A strobe while busy is flagged and otherwise dropped.
            if (!sys_adsn && state != IDLE && state != INIT)
                sys_err <= 1'b1;

            case (state)
                INIT: begin
                    if (init_cnt == INIT_TC) begin
                        state         <= IDLE;
                        sys_init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (!sys_adsn) begin
                        sram_addr <= sys_addr;
                        sram_dq_o <= sys_wdata;
                        sram_ce_n <= 1'b0;
                        if (sys_r_wn) begin
                            state      <= R_SETUP;
                            sram_oe_n  <= 1'b0;
                            sram_dq_oe <= 1'b0;
                        end else begin
                            state      <= W_SETUP;
                            sram_dq_oe <= 1'b1;
                        end
                    end
                end
                W_SETUP: begin
                    state     <= W_PULSE;
                    sram_we_n <= 1'b0;
                    wait_cnt  <= WAIT_LD;
                end
                W_PULSE: begin
                    if (wait_cnt == '0) begin
                        state     <= W_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                W_HOLD: begin
                    state      <= ACK;
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    done_w     <= 1'b1;
                    ack_cnt    <= ACK_LD;
                end
                R_SETUP: begin
                    state    <= R_WAIT;
                    wait_cnt <= WAIT_LD;
                end
                R_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ACK;
                        sys_rdata <= sram_dq_i;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        done_r    <= 1'b1;
                        ack_cnt   <= ACK_LD;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ACK: begin
                    if (ack_cnt == '0) begin
                        state  <= IDLE;
                        done_w <= 1'b0;
                        done_r <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt - 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_frfb_sram_resp.sv
// Bench for frfb_sram_resp: SRAM model plus a timing/data reference model
// derived from the access latencies, with randomized request traffic.
module tb_frfb_sram_resp;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int IC = 8;
    localparam int W  = 2;
    localparam int A  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] sys_addr;
    logic          sys_adsn;
    logic          sys_r_wn;
    logic [DW-1:0] sys_wdata;
    logic [DW-1:0] sys_rdata;
    logic          sys_init_done, done_w, done_r, sys_err;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    int tests = 0;
    int fails = 0;

    frfb_sram_resp #(
        .ADDR_W(AW), .DATA_W(DW), .INIT_CYCLES(IC),
        .WAIT_CYCLES(W), .ACK_CYCLES(A)
    ) dut (
        .clk(clk), .rst(rst),
        .sys_addr(sys_addr), .sys_adsn(sys_adsn), .sys_r_wn(sys_r_wn),
        .sys_wdata(sys_wdata), .sys_rdata(sys_rdata),
        .sys_init_done(sys_init_done), .done_w(done_w), .done_r(done_r),
        .sys_err(sys_err), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: write on rising we_n while selected.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int wr_count  = 0;
    int acc_count = 0;
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i) ^ 16'h5A5A;
    always @(posedge sram_we_n) if (sram_ce_n === 1'b0) begin
        mem[sram_addr] <= sram_dq_o;
        wr_count++;
    end
    always @(negedge sram_ce_n) acc_count++;
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0BAD;

    // Reference model state
    logic [DW-1:0] ref_mem [bit [AW-1:0]];
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    int            exp_wr;
    int            exp_acc;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return DW'(a) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts at a negedge in IDLE; ends at the negedge after the edge that
    // returns to IDLE, so an immediate second call is a back-to-back request.
    task automatic run_access(input bit rd, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int busy_k);
        int len;
        len = rd ? W + 1 + A : W + 2 + A;
        sys_adsn = 1'b0; sys_r_wn = rd; sys_addr = a; sys_wdata = d;
        @(posedge clk);
        @(negedge clk);
        sys_adsn = 1'b1; sys_addr = AW'($urandom); sys_wdata = DW'($urandom);
        exp_acc++;
        for (int k = 0; k <= len; k++) begin
            if (rd && k == W + 1) exp_rdata = ref_read(a);
            if (busy_k >= 0 && k == busy_k + 1) exp_err = 1'b1;
            if (sram_we_n !== (rd ? 1'b1 : !(k >= 1 && k <= W))) begin
                tests++; fails++;
                $display("FAIL we_n k=%0d rd=%0d: got %b", k, rd, sram_we_n);
            end else tests++;
            if (sram_oe_n !== (rd ? !(k <= W) : 1'b1)) begin
                tests++; fails++;
                $display("FAIL oe_n k=%0d rd=%0d: got %b", k, rd, sram_oe_n);
            end else tests++;
            if (sram_ce_n !== (rd ? !(k <= W) : !(k <= W + 1))) begin
                tests++; fails++;
                $display("FAIL ce_n k=%0d rd=%0d: got %b", k, rd, sram_ce_n);
            end else tests++;
            if (sram_dq_oe !== (!rd && k <= W + 1)) begin
                tests++; fails++;
                $display("FAIL dq_oe k=%0d rd=%0d: got %b", k, rd, sram_dq_oe);
            end else tests++;
            if (done_w !== (!rd && k >= W + 2 && k <= W + 1 + A)) begin
                tests++; fails++;
                $display("FAIL done_w k=%0d rd=%0d: got %b", k, rd, done_w);
            end else tests++;
            if (done_r !== (rd && k >= W + 1 && k <= W + A)) begin
                tests++; fails++;
                $display("FAIL done_r k=%0d rd=%0d: got %b", k, rd, done_r);
            end else tests++;
            if (done_w && done_r) begin
                tests++; fails++;
                $display("FAIL done_overlap k=%0d: both high", k);
            end else tests++;
            if (sram_addr !== a) begin
                tests++; fails++;
                $display("FAIL sram_addr k=%0d: got %h expected %h", k, sram_addr, a);
            end else tests++;
            if (!rd && sram_dq_o !== d) begin
                tests++; fails++;
                $display("FAIL sram_dq_o k=%0d: got %h expected %h", k, sram_dq_o, d);
            end else tests++;
            if (sys_rdata !== exp_rdata) begin
                tests++; fails++;
                $display("FAIL sys_rdata k=%0d: got %h expected %h", k, sys_rdata, exp_rdata);
            end else tests++;
            if (sys_err !== exp_err) begin
                tests++; fails++;
                $display("FAIL sys_err k=%0d: got %b expected %b", k, sys_err, exp_err);
            end else tests++;
            if (busy_k >= 0 && k == busy_k) begin
                sys_adsn = 1'b0; sys_r_wn = $urandom_range(0, 1);
                sys_addr = AW'($urandom); sys_wdata = DW'($urandom);
            end else begin
                sys_adsn = 1'b1;
            end
            if (k < len) @(negedge clk);
        end
        if (!rd) begin
            ref_mem[a] = d;
            exp_wr++;
        end
        chk("wr_count", wr_count, exp_wr);
        chk("acc_count", acc_count, exp_acc);
    endtask

    task automatic do_reset_release(input int adsn_k);
        sys_adsn = 1'b1; sys_r_wn = 1'b0; sys_addr = '0; sys_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0; exp_err = 1'b0;
        for (int k = 0; k <= IC + 1; k++) begin
            @(negedge clk);
            chk($sformatf("init_done_e%0d", k), sys_init_done, k >= IC);
            chk($sformatf("init_ce_n_e%0d", k), sram_ce_n, 1'b1);
            chk($sformatf("init_err_e%0d", k), sys_err, 1'b0);
            chk($sformatf("init_done_wr_e%0d", k), {done_w, done_r}, 2'b00);
            sys_adsn = !(k == adsn_k);
        end
        sys_adsn = 1'b1;
    endtask

    task automatic test_reset;
        sys_adsn = 1'b1; sys_r_wn = 1'b0; sys_addr = '0; sys_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_init_done", sys_init_done, 1'b0);
        chk("rst_dones", {done_w, done_r, sys_err, sram_dq_oe}, 4'b0000);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        chk("rst_addr", sram_addr, '0);
        chk("rst_dq_o", sram_dq_o, '0);
        chk("rst_rdata", sys_rdata, '0);
        do_reset_release(2);
        chk("init_acc", acc_count, exp_acc);
    endtask

    task automatic test_write;
        run_access(1'b0, 15'h1234, 16'hBEEF, -1);
    endtask

    task automatic test_read;
        ref_mem[15'h7FFF] = 16'hA5A5;
        mem[15'h7FFF] = 16'hA5A5;
        @(negedge clk);
        run_access(1'b1, 15'h7FFF, 16'h0000, -1);
        @(negedge clk);
        run_access(1'b1, 15'h1234, 16'h0000, -1);
    endtask

    task automatic test_back_to_back;
        run_access(1'b0, 15'h0042, 16'hC0DE, -1);
        run_access(1'b1, 15'h0042, 16'h0000, -1);
        run_access(1'b0, 15'h0043, 16'h1357, -1);
        run_access(1'b0, 15'h0042, 16'h2468, -1);
        run_access(1'b1, 15'h0042, 16'h0000, -1);
    endtask

    task automatic test_random;
        logic [AW-1:0] pool [4];
        pool[0] = 15'h0000; pool[1] = 15'h7FFF; pool[2] = 15'h2AAA; pool[3] = 15'h5555;
        for (int n = 0; n < 30; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            run_access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
                       DW'($urandom), -1);
        end
    endtask

    task automatic test_busy;
        @(negedge clk);
        run_access(1'b0, 15'h0101, 16'hFACE, 0);
        run_access(1'b1, 15'h0101, 16'h0000, 2);
        @(negedge clk);
        run_access(1'b1, 15'h0000, 16'h0000, -1);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        sys_adsn = 1'b0; sys_r_wn = 1'b0; sys_addr = 15'h0777; sys_wdata = 16'h9999;
        @(posedge clk);
        @(negedge clk);
        sys_adsn = 1'b1;
        @(negedge clk);
        chk("mid_in_pulse", sram_we_n, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_we_n", sram_we_n, 1'b1);
        chk("mid_ce_n", sram_ce_n, 1'b1);
        chk("mid_dq_oe", sram_dq_oe, 1'b0);
        chk("mid_init_done", sys_init_done, 1'b0);
        chk("mid_err", sys_err, 1'b0);
        chk("mid_done_w", done_w, 1'b0);
        exp_acc++;
        do_reset_release(-1);
        chk("mid_no_write", wr_count, exp_wr);
        chk("mid_mem", mem[15'h0777], 16'h0777 ^ 16'h5A5A);
        run_access(1'b1, 15'h0042, 16'h0000, -1);
        run_access(1'b0, 15'h0777, 16'h4321, -1);
        run_access(1'b1, 15'h0777, 16'h0000, -1);
    endtask

    initial begin
        exp_rdata = '0; exp_err = 1'b0; exp_wr = 0; exp_acc = 0;
        rst = 1'b1; sys_adsn = 1'b1; sys_r_wn = 1'b0; sys_addr = '0; sys_wdata = '0;
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_random;
        test_busy;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
